// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like arbiter.
// FSM states and sram-like transfer sizes.
package sram_like_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_prio_pick.sv
// Winner select between inst and data ports.
// Data wins ties until inst has lost STARVE_MAX grants in a row.
module arb_prio_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_fire,
    output logic pick_data
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          starved;

    assign starved   = (cnt_q == CW'(STARVE_MAX));
    assign pick_data = d_req && !(i_req && starved);

    always_comb begin
        cnt_d = cnt_q;
        if (grant_fire) begin
            if (!pick_data) begin
                cnt_d = '0;
            end else if (i_req && !starved) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like master port between inst and data slaves.
// One outstanding transaction; response routed to the registered owner.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e        state_q;
    logic              owner_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic grant_fire;
    logic pick_data;
    logic done;
    logic in_addr;

    assign in_addr    = (state_q == ARB_ADDR);
    assign grant_fire = !rst && (state_q == ARB_IDLE) && (i_req || d_req);

    arb_prio_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .d_req     (d_req),
        .grant_fire(grant_fire),
        .pick_data (pick_data)
    );

    // Stale m_data_ok in IDLE, or in ADDR without m_addr_ok, is dropped here.
    assign done = (in_addr && m_addr_ok && m_data_ok)
               || ((state_q == ARB_RESP) && m_data_ok);

    assign i_addr_ok = grant_fire && !pick_data;
    assign d_addr_ok = grant_fire && pick_data;
    assign i_data_ok = done && !owner_q;
    assign d_data_ok = done && owner_q;
    assign i_rdata   = i_data_ok ? m_rdata : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;

    assign m_req   = in_addr;
    assign m_wr    = in_addr ? wr_q    : 1'b0;
    assign m_size  = in_addr ? size_q  : 2'b00;
    assign m_addr  = in_addr ? addr_q  : '0;
    assign m_wdata = in_addr ? wdata_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_fire) begin
                        state_q <= ARB_ADDR;
                        owner_q <= pick_data;
                        if (pick_data) begin
                            wr_q    <= d_wr;
                            size_q  <= d_size;
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                        end else begin
                            wr_q    <= 1'b0;
                            size_q  <= SZ_WORD;
                            addr_q  <= i_addr;
                            wdata_q <= '0;
                        end
                    end
                end
                ARB_ADDR: begin
                    if (m_addr_ok) begin
                        state_q <= m_data_ok ? ARB_IDLE : ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (m_data_ok) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule
